change_dispenser: RTL
=====================

// Module: change_dispenser
// PURPOSE
//  Pays out change after a vending transaction by driving coin-hopper actuators.
//  Takes a latched amount from the transaction/credit logic (the same 20-bit count shown on the 7-seg).
//  Emits timed one-coin pulses, largest denomination first, and reports busy/done/fault.
//  Sits between the credit logic and the three hopper drivers.
// PARAMETERS
//  AMT_W      20         amount width, units of 0.5 yuan
//  PULSE_CYC  2_500_000  actuator high time per coin, cycles (50 ms @ 50 MHz)
//  GAP_CYC    2_500_000  mandatory low time between coins, cycles
//  DEN_HI     10         value of the hi coin (5.0 yuan)
//  DEN_MID    2          value of the mid coin (1.0 yuan)
//  DEN_LO     1          value of the lo coin (0.5 yuan)
// PORTS
//  clk        in   1      system clock
//  rst_n      in   1      asynchronous, active-low reset
//  req        in   1      one-cycle start strobe; sampled only in IDLE or FAULT
//  amount     in   AMT_W  change to pay; sampled on the req cycle
//  empty_hi   in   1      hi hopper empty (already synchronous)
//  empty_mid  in   1      mid hopper empty
//  empty_lo   in   1      lo hopper empty
//  coin_hi    out  1      hi actuator pulse
//  coin_mid   out  1      mid actuator pulse
//  coin_lo    out  1      lo actuator pulse
//  busy       out  1      payout in progress
//  done       out  1      one-cycle pulse: full amount paid
//  fault      out  1      sticky: cannot complete payout
//  paid_out   out  AMT_W  value dispensed so far in the current request
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, remaining=0, timer=0. Asserting rst_n low
//    mid-payout drops every coin output in the same instant (async).
//  - FSM IDLE -> SELECT -> PULSE -> GAP -> SELECT ... -> DONE -> IDLE; SELECT -> FAULT.
//  - IDLE/FAULT + req, amount>0: latch remaining=amount; paid_out=0; fault=0; busy=1; -> SELECT.
//  - IDLE/FAULT + req, amount==0: done=1 on the next cycle only; busy stays 0; no coins.
//  - SELECT (1 cycle): pick the largest d in {HI, MID, LO} with remaining>=d and hopper not empty.
//    Empty inputs are sampled in this cycle.
//    * remaining==0 -> DONE.
//    * no eligible d -> FAULT.
//    * otherwise -> PULSE, timer=PULSE_CYC.
//  - PULSE: only the chosen coin output is high, for exactly PULSE_CYC cycles. On the last cycle,
//    remaining-=d and paid_out+=d (registered, visible next cycle). Then -> GAP.
//    An empty_* change during PULSE does not abort the pulse.
//  - GAP: all coin outputs low for exactly GAP_CYC cycles, then -> SELECT.
//  - DONE: done=1 for 1 cycle, busy=0 from the same cycle, then -> IDLE.
//  - FAULT: fault=1 and busy=0; paid_out holds. Leaves only on req or reset.
//  - req while busy is ignored; amount changes while busy are ignored.
//  - At most one coin output is high in any cycle. Coin outputs are registered (no glitches).
//  - Latency: req at cycle 0 -> SELECT at 1 -> coin high at cycles 2..PULSE_CYC+1.
//  - Width: the subtraction never underflows (guarded by remaining>=d); paid_out<=amount always.
//  - Timer width: $clog2(max(PULSE_CYC, GAP_CYC)+1).
// STRUCTURE
//  - Shared include vm_defs.vh holds the state encodings and the default denomination constants.
//    The credit counter uses the same constants.
//  - One sub-module, pulse_timer: loadable down-counter with load, value and a zero flag.
//    The FSM reuses it for both PULSE and GAP.
//  - FSM, remaining/paid_out registers and coin select logic stay in change_dispenser.
// TESTING (bench params PULSE_CYC=4, GAP_CYC=2)
//  1. amount=17, no hoppers empty -> pulses hi x1, mid x3, lo x1 in that order;
//     paid_out=17; one done pulse; fault=0.
//  2. req at cycle 0, amount=10 -> coin_hi high cycles 2-5, low 6-7; done at cycle 9;
//     busy high 1-8.
//  3. amount=0 -> done at cycle 1 only; busy never high; no coin pulses.
//  4. empty_hi=1, amount=10 -> five mid pulses; paid_out=10; done.
//  5. empty_mid=empty_lo=1, amount=13 -> one hi pulse, then fault=1 sticky, paid_out=10.
//     A later req with amount=0 clears fault and gives done.
//  6. req pulsed again mid-payout -> ignored. rst_n low during a coin_mid pulse ->
//     all outputs 0 at once; after release, state IDLE with paid_out=0.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: FSM state encoding,
// coin select codes and default denominations/timing.
package change_dispenser_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_PULSE  = 3'd2,
      ST_GAP    = 3'd3,
      ST_DONE   = 3'd4,
      ST_FAULT  = 3'd5
   } state_e;

   // Coin actuator vector order is {hi, mid, lo}
   localparam logic [2:0] COIN_NONE = 3'b000;
   localparam logic [2:0] COIN_HI   = 3'b100;
   localparam logic [2:0] COIN_MID  = 3'b010;
   localparam logic [2:0] COIN_LO   = 3'b001;

   localparam int AMT_W_DEF     = 20;
   localparam int PULSE_CYC_DEF = 2_500_000;
   localparam int GAP_CYC_DEF   = 2_500_000;
   localparam int DEN_HI_DEF    = 10;
   localparam int DEN_MID_DEF   = 2;
   localparam int DEN_LO_DEF    = 1;

   function automatic int max_i(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/change_dispenser_pulse_timer.sv
// Loadable down-counter shared by the coin pulse and the inter-coin gap.
// Holds at zero until reloaded.
module change_dispenser_pulse_timer #(
   parameter int TW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic [TW-1:0] value,
   output logic          zero
);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - TW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign value = cnt_q;
   assign zero  = (cnt_q == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change payout controller: greedy largest-coin-first dispensing with
// timed actuator pulses, hopper-empty fault detection and progress report.
module change_dispenser
   import change_dispenser_pkg::*;
#(
   parameter int AMT_W     = AMT_W_DEF,
   parameter int PULSE_CYC = PULSE_CYC_DEF,
   parameter int GAP_CYC   = GAP_CYC_DEF,
   parameter int DEN_HI    = DEN_HI_DEF,
   parameter int DEN_MID   = DEN_MID_DEF,
   parameter int DEN_LO    = DEN_LO_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req,
   input  logic [AMT_W-1:0] amount,
   input  logic             empty_hi,
   input  logic             empty_mid,
   input  logic             empty_lo,
   output logic             coin_hi,
   output logic             coin_mid,
   output logic             coin_lo,
   output logic             busy,
   output logic             done,
   output logic             fault,
   output logic [AMT_W-1:0] paid_out
);

   localparam int TW = $clog2(max_i(PULSE_CYC, GAP_CYC) + 1);

   localparam logic [AMT_W-1:0] D_HI  = AMT_W'(DEN_HI);
   localparam logic [AMT_W-1:0] D_MID = AMT_W'(DEN_MID);
   localparam logic [AMT_W-1:0] D_LO  = AMT_W'(DEN_LO);

   state_e           state_q, state_d;
   logic [AMT_W-1:0] rem_q, rem_d;
   logic [AMT_W-1:0] paid_q, paid_d;
   logic [2:0]       coin_q, coin_d;

   logic             tmr_load;
   logic [TW-1:0]    tmr_load_val;
   logic [TW-1:0]    tmr_value;
   logic             tmr_zero;
   logic             tmr_last;

   logic             ok_hi, ok_mid, ok_lo;
   logic [AMT_W-1:0] den;

   change_dispenser_pulse_timer #(
      .TW (TW)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .value    (tmr_value),
      .zero     (tmr_zero)
   );

   // Expired-at-zero also ends the phase, so a stale timer cannot stall it
   assign tmr_last = tmr_zero || (tmr_value == TW'(1));

   assign ok_hi  = (rem_q >= D_HI)  && !empty_hi;
   assign ok_mid = (rem_q >= D_MID) && !empty_mid;
   assign ok_lo  = (rem_q >= D_LO)  && !empty_lo;

   always_comb begin
      den = D_LO;
      unique case (1'b1)
         coin_q[2]: den = D_HI;
         coin_q[1]: den = D_MID;
         default:   den = D_LO;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      rem_d        = rem_q;
      paid_d       = paid_q;
      coin_d       = coin_q;
      tmr_load     = 1'b0;
      tmr_load_val = '0;
      unique case (state_q)
         ST_IDLE, ST_FAULT: begin
            if (req) begin
               paid_d = '0;
               if (amount != '0) begin
                  rem_d   = amount;
                  state_d = ST_SELECT;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_SELECT: begin
            tmr_load_val = TW'(PULSE_CYC);
            if (rem_q == '0) begin
               state_d = ST_DONE;
            end else if (ok_hi) begin
               coin_d   = COIN_HI;
               tmr_load = 1'b1;
               state_d  = ST_PULSE;
            end else if (ok_mid) begin
               coin_d   = COIN_MID;
               tmr_load = 1'b1;
               state_d  = ST_PULSE;
            end else if (ok_lo) begin
               coin_d   = COIN_LO;
               tmr_load = 1'b1;
               state_d  = ST_PULSE;
            end else begin
               state_d = ST_FAULT;
            end
         end
         ST_PULSE: begin
            if (tmr_last) begin
               coin_d       = COIN_NONE;
               rem_d        = rem_q - den;
               paid_d       = paid_q + den;
               tmr_load     = 1'b1;
               tmr_load_val = TW'(GAP_CYC);
               state_d      = ST_GAP;
            end
         end
         ST_GAP: begin
            if (tmr_last) begin
               state_d = ST_SELECT;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            coin_d  = COIN_NONE;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         rem_q   <= '0;
         paid_q  <= '0;
         coin_q  <= COIN_NONE;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         paid_q  <= paid_d;
         coin_q  <= coin_d;
      end
   end

   assign coin_hi  = coin_q[2];
   assign coin_mid = coin_q[1];
   assign coin_lo  = coin_q[0];
   assign busy     = (state_q == ST_SELECT) ||
                     (state_q == ST_PULSE)  ||
                     (state_q == ST_GAP);
   assign done     = (state_q == ST_DONE);
   assign fault    = (state_q == ST_FAULT);
   assign paid_out = paid_q;

endmodule
